// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared unit IDs, latency limits and CDB booking entry type for the issue scheduler.
package issue_pkg;

  localparam logic [1:0] UNIT_INT  = 2'd0;
  localparam logic [1:0] UNIT_MEM  = 2'd1;
  localparam logic [1:0] UNIT_MULT = 2'd2;
  localparam logic [1:0] UNIT_DIV  = 2'd3;

  localparam int INT_LAT = 1;
  localparam int MAX_LAT = 7;

  typedef struct packed {
    logic       valid;
    logic [1:0] owner;
  } book_entry_t;

endpackage

// File: rtl/cdb_slot_tracker.sv
// rtl/cdb_slot_tracker.sv - CDB booking shift register; slot k means "CDB busy k cycles from now".
module cdb_slot_tracker
  import issue_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  input  logic [MAX_LAT:1]        i_set,
  input  logic [MAX_LAT:1][1:0]   i_set_owner,
  output logic [MAX_LAT:1]        o_slot_free,
  output logic                    o_cdb_valid,
  output logic [1:0]              o_cdb_owner
);

  book_entry_t [MAX_LAT:1] r_tab;
  book_entry_t [MAX_LAT:1] w_eff;
  logic                    r_cdb_valid;
  logic [1:0]              r_cdb_owner;

  // Same-cycle bookings merge in before the shift so they land one slot lower next cycle.
  always_comb begin
    w_eff       = r_tab;
    o_slot_free = '0;
    for (int k = 1; k <= MAX_LAT; k++) begin
      o_slot_free[k] = !r_tab[k].valid;
      if (i_set[k]) begin
        w_eff[k].valid = 1'b1;
        w_eff[k].owner = i_set_owner[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tab       <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_owner <= 2'd0;
    end else if (i_flush) begin
      r_tab       <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_owner <= 2'd0;
    end else begin
      for (int k = 1; k < MAX_LAT; k++) begin
        r_tab[k] <= w_eff[k+1];
      end
      r_tab[MAX_LAT] <= '0;
      r_cdb_valid    <= w_eff[1].valid;
      r_cdb_owner    <= w_eff[1].owner;
    end
  end

  assign o_cdb_valid = r_cdb_valid;
  assign o_cdb_owner = r_cdb_owner;

endmodule

// File: rtl/issue_unit.sv
// rtl/issue_unit.sv - issue scheduler granting reservation stations against CDB bookings.
// Optional conflict-stall counter enabled by ISSUE_PERF_CNT_EN.
module issue_unit
  import issue_pkg::*;
#(
  parameter int MEM_LAT  = 1,
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 6
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic [3:0]  i_rdy,
  output logic [3:0]  o_issue,
  output logic        o_cdb_valid,
  output logic [1:0]  o_cdb_owner,
  output logic        o_div_busy,
  output logic [15:0] o_conflict_cnt
);

  if (!(MEM_LAT >= 1 && MEM_LAT <= MAX_LAT && MULT_LAT >= 2 && MULT_LAT <= MAX_LAT &&
        DIV_LAT >= 2 && DIV_LAT <= MAX_LAT && MULT_LAT != DIV_LAT &&
        MEM_LAT != MULT_LAT && MEM_LAT != DIV_LAT)) begin : g_bad_lat
    $error("issue_unit: illegal latency configuration");
  end

  logic [MAX_LAT:1]      w_slot_free;
  logic [MAX_LAT:1]      w_set;
  logic [MAX_LAT:1][1:0] w_set_owner;
  logic [3:0]            w_elig;
  logic [3:0]            w_grant;
  logic                  w_rr_conf;
  logic                  r_rr;
  logic [2:0]            r_div_cnt;

  assign o_div_busy = (r_div_cnt != 3'd0);

  always_comb begin
    w_elig[UNIT_INT]  = i_rdy[UNIT_INT]  & w_slot_free[INT_LAT]  & !i_flush;
    w_elig[UNIT_MEM]  = i_rdy[UNIT_MEM]  & w_slot_free[MEM_LAT]  & !i_flush;
    w_elig[UNIT_MULT] = i_rdy[UNIT_MULT] & w_slot_free[MULT_LAT] & !i_flush;
    w_elig[UNIT_DIV]  = i_rdy[UNIT_DIV]  & w_slot_free[DIV_LAT]  & !i_flush & !o_div_busy;
    // Only INT and MEM can share a target slot; r_rr=1 means MEM currently preferred.
    w_rr_conf = (MEM_LAT == INT_LAT) && w_elig[UNIT_INT] && w_elig[UNIT_MEM];
    w_grant   = w_elig;
    if (w_rr_conf) begin
      if (r_rr) w_grant[UNIT_INT] = 1'b0;
      else      w_grant[UNIT_MEM] = 1'b0;
    end
  end

  always_comb begin
    w_set       = '0;
    w_set_owner = '0;
    if (w_grant[UNIT_INT]) begin
      w_set[INT_LAT]       = 1'b1;
      w_set_owner[INT_LAT] = UNIT_INT;
    end
    if (w_grant[UNIT_MEM]) begin
      w_set[MEM_LAT]       = 1'b1;
      w_set_owner[MEM_LAT] = UNIT_MEM;
    end
    if (w_grant[UNIT_MULT]) begin
      w_set[MULT_LAT]       = 1'b1;
      w_set_owner[MULT_LAT] = UNIT_MULT;
    end
    if (w_grant[UNIT_DIV]) begin
      w_set[DIV_LAT]       = 1'b1;
      w_set_owner[DIV_LAT] = UNIT_DIV;
    end
  end

  assign o_issue = w_grant & {4{i_rst_n}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr      <= 1'b0;
      r_div_cnt <= 3'd0;
    end else begin
      if (w_rr_conf) r_rr <= !r_rr;
      if (i_flush)                 r_div_cnt <= 3'd0;
      else if (w_grant[UNIT_DIV])  r_div_cnt <= 3'(DIV_LAT - 1);
      else if (o_div_busy)         r_div_cnt <= r_div_cnt - 3'd1;
    end
  end

  cdb_slot_tracker u_tracker (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_flush),
    .i_set       (w_set),
    .i_set_owner (w_set_owner),
    .o_slot_free (w_slot_free),
    .o_cdb_valid (o_cdb_valid),
    .o_cdb_owner (o_cdb_owner)
  );

`ifdef ISSUE_PERF_CNT_EN
  logic [3:0]  w_blocked;
  logic [2:0]  w_stalls;
  logic [16:0] w_sum;
  logic [15:0] r_conflict_cnt;

  always_comb begin
    w_blocked[UNIT_INT]  = i_rdy[UNIT_INT]  & !w_slot_free[INT_LAT]  & !i_flush;
    w_blocked[UNIT_MEM]  = i_rdy[UNIT_MEM]  & !w_slot_free[MEM_LAT]  & !i_flush;
    w_blocked[UNIT_MULT] = i_rdy[UNIT_MULT] & !w_slot_free[MULT_LAT] & !i_flush;
    w_blocked[UNIT_DIV]  = i_rdy[UNIT_DIV]  & !w_slot_free[DIV_LAT]  & !i_flush;
    w_stalls = {2'b0, w_blocked[0]} + {2'b0, w_blocked[1]} + {2'b0, w_blocked[2]} +
               {2'b0, w_blocked[3]} + {2'b0, w_rr_conf};
    w_sum    = {1'b0, r_conflict_cnt} + {14'b0, w_stalls};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_conflict_cnt <= 16'd0;
    else          r_conflict_cnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
  end

  assign o_conflict_cnt = r_conflict_cnt;
`else
  assign o_conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_issue_unit.sv
// tb/tb_issue_unit.sv - table-driven bench for issue_unit with a CDB-owner scoreboard.
module tb_issue_unit;
  import issue_pkg::*;

  localparam int MEM_L = 1, MULT_L = 4, DIV_L = 6;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic [3:0]  i_rdy = 4'b0;
  logic [3:0]  o_issue;
  logic        o_cdb_valid;
  logic [1:0]  o_cdb_owner;
  logic        o_div_busy;
  logic [15:0] o_conflict_cnt;

  issue_unit #(.MEM_LAT(MEM_L), .MULT_LAT(MULT_L), .DIV_LAT(DIV_L)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_flush        (i_flush),
    .i_rdy          (i_rdy),
    .o_issue        (o_issue),
    .o_cdb_valid    (o_cdb_valid),
    .o_cdb_owner    (o_cdb_owner),
    .o_div_busy     (o_div_busy),
    .o_conflict_cnt (o_conflict_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       flush;
    logic [3:0] rdy;
    logic [3:0] exp_issue;
    logic       exp_busy;
    int         stall;
  } vec_t;

  typedef struct {
    int         due;
    logic [1:0] owner;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic addn(int n, logic f, logic [3:0] r, logic [3:0] ei, logic eb, int st);
    vec_t v;
    v.flush = f; v.rdy = r; v.exp_issue = ei; v.exp_busy = eb; v.stall = st;
    for (int j = 0; j < n; j++) vecs.push_back(v);
  endtask

  function automatic int lat_of(int u);
    case (u)
      0:       return INT_LAT;
      1:       return MEM_L;
      2:       return MULT_L;
      default: return DIV_L;
    endcase
  endfunction

  function automatic int cnt_exp(int n);
`ifdef ISSUE_PERF_CNT_EN
    return (n > 65535) ? 65535 : n;
`else
    return 0;
`endif
  endfunction

  task automatic check_cdb(int c);
    int idx;
    idx = -1;
    foreach (sb[j]) if (sb[j].due == c) idx = j;
    if (idx >= 0) begin
      chk($sformatf("cdb_valid@%0d", c), 32'(o_cdb_valid), 32'd1);
      chk($sformatf("cdb_owner@%0d", c), 32'(o_cdb_owner), 32'(sb[idx].owner));
      sb.delete(idx);
    end else begin
      chk($sformatf("cdb_idle@%0d", c), 32'(o_cdb_valid), 32'd0);
    end
  endtask

  initial begin
    // Reset state with every station ready: nothing may be granted.
    i_rst_n = 1'b0;
    i_rdy   = 4'b1111;
    #1;
    chk("rst_issue", 32'(o_issue), 32'd0);
    chk("rst_cdb_valid", 32'(o_cdb_valid), 32'd0);
    chk("rst_cdb_owner", 32'(o_cdb_owner), 32'd0);
    chk("rst_div_busy", 32'(o_div_busy), 32'd0);
    chk("rst_cnt", 32'(o_conflict_cnt), 32'd0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_rdy   = 4'b0;

    // INT single issue
    addn(1, 0, 4'b0001, 4'b0001, 0, 0);
    addn(2, 0, 4'b0000, 4'b0000, 0, 0);
    // INT/MEM slot-1 conflict, INT preferred first
    addn(1, 0, 4'b0011, 4'b0001, 0, 1);
    addn(1, 0, 4'b0010, 4'b0010, 0, 0);
    addn(1, 0, 4'b0000, 4'b0000, 0, 0);
    // MULT booking blocks INT three cycles later
    addn(1, 0, 4'b0100, 4'b0100, 0, 0);
    addn(2, 0, 4'b0000, 4'b0000, 0, 0);
    addn(1, 0, 4'b0001, 4'b0000, 0, 1);
    addn(1, 0, 4'b0001, 4'b0001, 0, 0);
    addn(1, 0, 4'b0000, 4'b0000, 0, 0);
    // DIV non-pipelined back-to-back
    addn(1, 0, 4'b1000, 4'b1000, 0, 0);
    addn(5, 0, 4'b1000, 4'b0000, 1, 0);
    addn(1, 0, 4'b1000, 4'b1000, 0, 0);
    addn(5, 0, 4'b0000, 4'b0000, 1, 0);
    // MEM now preferred; multi-grant; MULT blocked by DIV booking
    addn(1, 0, 4'b0111, 4'b0110, 0, 1);
    addn(1, 0, 4'b1101, 4'b1101, 0, 0);
    addn(1, 0, 4'b0100, 4'b0100, 1, 0);
    addn(1, 0, 4'b0100, 4'b0000, 1, 1);
    addn(3, 0, 4'b0000, 4'b0000, 1, 0);
    // Flush squashes MULT booking and DIV busy
    addn(1, 0, 4'b0100, 4'b0100, 0, 0);
    addn(1, 0, 4'b0000, 4'b0000, 0, 0);
    addn(1, 1, 4'b0001, 4'b0000, 0, 0);
    addn(2, 0, 4'b0000, 4'b0000, 0, 0);
    addn(1, 0, 4'b1000, 4'b1000, 0, 0);
    addn(1, 1, 4'b1000, 4'b0000, 1, 0);
    addn(1, 0, 4'b0000, 4'b0000, 0, 0);
    addn(1, 0, 4'b1000, 4'b1000, 0, 0);
    addn(5, 0, 4'b0000, 4'b0000, 1, 0);
    addn(1, 0, 4'b0000, 4'b0000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge i_clk);
      #1;
      i_flush = vecs[i].flush;
      i_rdy   = vecs[i].rdy;
      #3;
      chk($sformatf("issue@%0d", i), 32'(o_issue), 32'(vecs[i].exp_issue));
      chk($sformatf("div_busy@%0d", i), 32'(o_div_busy), 32'(vecs[i].exp_busy));
      chk($sformatf("cnt@%0d", i), 32'(o_conflict_cnt), 32'(cnt_exp(exp_cnt)));
      check_cdb(i);
      exp_cnt += vecs[i].stall;
      if (vecs[i].flush) begin
        for (int j = sb.size() - 1; j >= 0; j--) if (sb[j].due > i) sb.delete(j);
      end
      for (int u = 0; u < 4; u++) begin
        if (vecs[i].exp_issue[u]) sb.push_back('{due: i + lat_of(u), owner: 2'(u)});
      end
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the middle of activity
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    i_rdy   = 4'b1001;
    #3;
    chk("mr_issue", 32'(o_issue), 32'b1001);
    chk("mr_cnt_pre", 32'(o_conflict_cnt), 32'(cnt_exp(exp_cnt)));
    @(posedge i_clk);
    #1;
    i_rdy = 4'b0001;
    #1;
    chk("mr_cdb_valid_pre", 32'(o_cdb_valid), 32'd1);
    chk("mr_div_busy_pre", 32'(o_div_busy), 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("mr_cdb_valid", 32'(o_cdb_valid), 32'd0);
    chk("mr_div_busy", 32'(o_div_busy), 32'd0);
    chk("mr_issue_rst", 32'(o_issue), 32'd0);
    chk("mr_cnt", 32'(o_conflict_cnt), 32'd0);

    // Sustained INT/MEM conflict: one stall per cycle, counter saturates
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_rdy   = 4'b0011;
    #3;
    chk("rr_first_int", 32'(o_issue), 32'b0001);
    @(posedge i_clk);
    #3;
    chk("rr_then_mem", 32'(o_issue), 32'b0010);
    repeat (69999) @(posedge i_clk);
    #1;
    i_rdy = 4'b0000;
    #1;
    chk("cnt_saturated", 32'(o_conflict_cnt), 32'(cnt_exp(70000)));
    repeat (8) @(posedge i_clk);
    #1;
    chk("drained_cdb", 32'(o_cdb_valid), 32'd0);
    chk("cnt_held", 32'(o_conflict_cnt), 32'(cnt_exp(70000)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
